// File: rtl/frame_timer_pkg.sv
// Shared definitions for the frame tick timer.
//   state_e       : controller state (IDLE, RUN)
//   MODE_*        : meaning of the mode input, sampled at start
//   DEF_FPS       : default period in frames (one second at 60 Hz refresh)
package frame_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEF_FPS = 60;

endpackage

// File: rtl/frame_tick_timer_if.sv
// Control/status bundle of the frame tick timer.
//   tick, start, stop, mode, load, period_in : controls (master -> slave)
//   rdy, pre_rdy, count, running, secs       : status  (slave -> master)
//
// Signalling: there is no valid/ready pairing here. Every control input is a
// single-cycle strobe qualified only by being high on a rising clk edge, and
// is never back-pressured; every status output is a registered value or a
// one-cycle pulse that the consumer must sample on the cycle it is high.
interface frame_tick_timer_if #(
  parameter int CW = 8,
  parameter int SW = 8
);
  logic          tick;
  logic          start;
  logic          stop;
  logic          mode;
  logic          load;
  logic [CW-1:0] period_in;
  logic          rdy;
  logic          pre_rdy;
  logic [CW-1:0] count;
  logic          running;
  logic [SW-1:0] secs;

  modport master (
    output tick, start, stop, mode, load, period_in,
    input  rdy, pre_rdy, count, running, secs
  );

  modport slave (
    input  tick, start, stop, mode, load, period_in,
    output rdy, pre_rdy, count, running, secs
  );
endinterface

// File: rtl/frame_tick_timer_mod_counter.sv
// Modulo counter with runtime modulus.
//   clk, rst : clock, synchronous active-low reset
//   en       : advance by one
//   clr      : force count to zero (wins over en)
//   modulus  : wrap point; count runs 0..modulus-1
//   count    : registered count
//   wrap     : combinational, high when en would take count back to zero
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    wrap    = en && (count_q == modulus - 1'b1);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/frame_tick_timer.sv
// Frame-based interval timer: counts tick strobes up to a loadable period,
// pulses rdy on wrap and pre_rdy LEAD ticks earlier, periodic or one-shot.
//   clk, rst  : clock, synchronous active-low reset
//   bus       : control/status bundle (slave side)
//   dbg_state : current controller state
module frame_tick_timer
  import frame_timer_pkg::*;
#(
  parameter int          CW         = 8,
  parameter int          SW         = 8,
  parameter int          DEF_PERIOD = DEF_FPS,
  parameter int unsigned LEAD       = 1
) (
  input  logic                clk,
  input  logic                rst,
  frame_tick_timer_if.slave   bus,
  output state_e              dbg_state
);

  localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] active_q, active_d;
  logic [SW-1:0] secs_q, secs_d;
  logic          rdy_q, rdy_d;
  logic          pre_rdy_q, pre_rdy_d;

  logic          cnt_en;
  logic          cnt_clr;
  logic          cnt_wrap;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   active_ext;
  logic [31:0]   next_ext;
  logic [31:0]   pre_target;
  logic          pre_hit;

  // A tick only counts in RUN, and start/stop in the same cycle swallow it.
  always_comb begin
    cnt_clr = bus.stop | bus.start;
    cnt_en  = (state_q == RUN) & bus.tick & ~bus.stop & ~bus.start;
  end

  mod_counter #(.W(CW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .modulus (active_q),
    .count   (count),
    .wrap    (cnt_wrap)
  );

  // Early warning: compare the count this tick moves to against
  // (active - LEAD) mod active. LEAD = 0 folds onto 0, i.e. the wrap itself;
  // LEAD >= active disables the pulse entirely.
  always_comb begin
    count_next = cnt_wrap ? '0 : count + 1'b1;
    active_ext = 32'(active_q);
    next_ext   = 32'(count_next);
    pre_target = (LEAD == 0) ? 32'd0 : active_ext - LEAD;
    pre_hit    = cnt_en && (LEAD < active_ext) && (next_ext == pre_target);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    active_d  = active_q;
    secs_d    = secs_q;
    rdy_d     = 1'b0;
    pre_rdy_d = pre_hit;
    // A zero period would never wrap, so it is dropped at the shadow.
    shadow_d  = (bus.load && (bus.period_in != '0)) ? bus.period_in : shadow_q;

    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d  = RUN;
      mode_d   = bus.mode;
      active_d = shadow_d;
      secs_d   = '0;
    end else if (cnt_wrap) begin
      rdy_d    = 1'b1;
      secs_d   = secs_q + 1'b1;
      // shadow_d so that a load in the wrap cycle takes effect immediately.
      active_d = shadow_d;
      if (mode_q == MODE_ONESHOT) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_PERIODIC;
      shadow_q  <= DEF_P;
      active_q  <= DEF_P;
      secs_q    <= '0;
      rdy_q     <= 1'b0;
      pre_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      secs_q    <= secs_d;
      rdy_q     <= rdy_d;
      pre_rdy_q <= pre_rdy_d;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.pre_rdy = pre_rdy_q;
  assign bus.count   = count;
  assign bus.running = (state_q == RUN);
  assign bus.secs    = secs_q;
  assign dbg_state   = state_q;

endmodule
